// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: FSM state encoding and a table of maximal-length
// Galois tap masks (implicit x^n term omitted) for register widths 3..32.
package lfsr_pkg;

    typedef enum logic [1:0] {
        StInit   = 2'd0,
        StRun    = 2'd1,
        StLocked = 2'd2
    } lfsr_state_e;

    function automatic logic [31:0] default_taps(input int unsigned nbits);
        logic [31:0] taps;
        taps = 32'h0;
        case (nbits)
            3:       taps = 32'h0000_0003;
            4:       taps = 32'h0000_0003;
            5:       taps = 32'h0000_0005;
            6:       taps = 32'h0000_0003;
            7:       taps = 32'h0000_0003;
            8:       taps = 32'h0000_001D;
            9:       taps = 32'h0000_0011;
            10:      taps = 32'h0000_0009;
            11:      taps = 32'h0000_0005;
            12:      taps = 32'h0000_0053;
            13:      taps = 32'h0000_001B;
            14:      taps = 32'h0000_0443;
            15:      taps = 32'h0000_0003;
            16:      taps = 32'h0000_100B;
            17:      taps = 32'h0000_0009;
            18:      taps = 32'h0000_0081;
            19:      taps = 32'h0000_0027;
            20:      taps = 32'h0000_0009;
            21:      taps = 32'h0000_0005;
            22:      taps = 32'h0000_0003;
            23:      taps = 32'h0000_0021;
            24:      taps = 32'h0000_0087;
            25:      taps = 32'h0000_0009;
            26:      taps = 32'h0000_0047;
            27:      taps = 32'h0000_0027;
            28:      taps = 32'h0000_0009;
            29:      taps = 32'h0000_0005;
            30:      taps = 32'h0000_0053;
            31:      taps = 32'h0000_0009;
            32:      taps = 32'h0040_0007;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Valid/ready output stream of the LFSR generator.
interface lfsr_gen_if #(
    parameter int unsigned NBITS = 8
) ();

    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] lfsr;

    modport master (
        output out_valid,
        output lfsr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  lfsr,
        output out_ready
    );

endinterface

// File: rtl/lfsr_step.sv
// One Galois LFSR shift: left shift, XOR taps when the (optionally inverted) MSB is set.
module lfsr_step #(
    parameter int unsigned      NBITS  = 8,
    parameter logic [NBITS-1:0] TAPS   = NBITS'(8'h1D),
    parameter bit               INVERT = 1'b0
) (
    input  logic [NBITS-1:0] cur,
    output logic [NBITS-1:0] nxt
);

    logic fb;

    assign fb  = cur[NBITS-1] ^ INVERT;
    assign nxt = {cur[NBITS-2:0], 1'b0} ^ (fb ? TAPS : '0);

endmodule

// File: rtl/lfsr_gen.sv
// Galois LFSR generator with valid/ready output, lockup recovery and period measurement.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      NBITS  = 8,
    parameter logic [NBITS-1:0] TAPS   = NBITS'(default_taps(NBITS)),
    parameter bit               INVERT = 1'b0,
    parameter logic [NBITS-1:0] SEED   = '1,
    parameter int unsigned      STEPS  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [NBITS-1:0] seed_in,
    lfsr_gen_if.master       stream,
    output logic             lockup,
    output logic             wrap,
    output logic [NBITS-1:0] period
);

    lfsr_state_e      state_q, state_d;
    logic [NBITS-1:0] lfsr_q, lfsr_d;
    logic [NBITS-1:0] start_q, start_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] period_q, period_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic [NBITS-1:0] lfsr_nxt;
    logic             out_valid;
    logic             advance;

    // STEPS single shifts chained combinationally; each stage feeds the next.
    for (genvar i = 0; i < STEPS; i++) begin : g_step
        logic [NBITS-1:0] cur;
        logic [NBITS-1:0] nxt;
        if (i == 0) begin : g_first
            assign cur = lfsr_q;
        end else begin : g_rest
            assign cur = g_step[i-1].nxt;
        end
        lfsr_step #(
            .NBITS  (NBITS),
            .TAPS   (TAPS),
            .INVERT (INVERT)
        ) u_step (
            .cur (cur),
            .nxt (nxt)
        );
    end

    assign lfsr_nxt  = g_step[STEPS-1].nxt;
    assign out_valid = (state_q == StRun);
    assign advance   = out_valid & enable & stream.out_ready;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        lockup_d = lockup_q;
        wrap_d   = 1'b0;
        if (seed_load) begin
            // Any handshake this cycle is treated as consumed; the load simply wins.
            lfsr_d   = seed_in;
            start_d  = seed_in;
            cnt_d    = '0;
            lockup_d = 1'b0;
            state_d  = StInit;
        end else begin
            unique case (state_q)
                StInit: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (advance) begin
                        if (lfsr_nxt == lfsr_q) begin
                            lockup_d = 1'b1;
                            state_d  = StLocked;
                        end else begin
                            lfsr_d = lfsr_nxt;
                            if (lfsr_nxt == start_q) begin
                                wrap_d   = 1'b1;
                                period_d = cnt_q + 1'b1;
                                cnt_d    = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                StLocked: begin
                    // lockup stays sticky until the next seed_load or reset.
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                    state_d = StInit;
                end
                default: begin
                    state_d = StInit;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StInit;
            lfsr_q   <= SEED;
            start_q  <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign stream.out_valid = out_valid;
    assign stream.lfsr      = lfsr_q;
    assign lockup           = lockup_q;
    assign wrap             = wrap_q;
    assign period           = period_q;

endmodule
